// File: rtl/pix_clk_monitor.sv
// pix_clk_monitor
//   Watches a pixel clock sampled as data in the clk_in domain. Measures the
//   rise-to-rise period and the high time, declares the clock good (clk_ok)
//   after LOCK_PERIODS consecutive in-tolerance periods, and raises a sticky
//   fault when a locked clock goes out of spec or stops.
//
// Ports
//   clk_in      : monitor (board) clock
//   rst         : asynchronous active-low reset
//   pix_clk     : monitored clock, treated as asynchronous data
//   pll_locked  : generator stable flag, synchronous to clk_in
//   fault_clr   : one-cycle request to clear the fault and restart acquisition
//   pix_rise    : one-cycle pulse per detected pix_clk rising edge
//   pix_fall    : one-cycle pulse per detected pix_clk falling edge
//   clk_ok      : pixel clock verified in spec
//   clk_fault   : sticky fault flag
//   fault_count : saturating count of faults
//   period_meas : last measured rise-to-rise period in clk_in cycles
module pix_clk_monitor #(
  parameter int DIV_PIX      = 4,
  parameter int LOCK_PERIODS = 8,
  parameter int TOL          = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             pix_clk,
  input  logic             pll_locked,
  input  logic             fault_clr,
  output logic             pix_rise,
  output logic             pix_fall,
  output logic             clk_ok,
  output logic             clk_fault,
  output logic [7:0]       fault_count,
  output logic [CNT_W-1:0] period_meas
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * DIV_PIX);
  localparam logic [CNT_W:0]   PER_EXP     = (CNT_W+1)'(DIV_PIX);
  localparam logic [CNT_W:0]   HI_EXP      = (CNT_W+1)'(DIV_PIX / 2);
  localparam logic [CNT_W:0]   TOL_W       = (CNT_W+1)'(TOL);
  localparam logic [7:0]       LOCK_N      = 8'(LOCK_PERIODS);

  // One extra bit so the difference of two unsigned counts never wraps.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W:0]   b);
    logic [CNT_W:0] a_w;
    a_w = {1'b0, a};
    return (a_w >= b) ? (a_w - b) : (b - a_w);
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [CNT_W-1:0]       r_per_cnt;
  logic [CNT_W-1:0]       r_hi_cnt;
  logic                   r_have_ref;
  logic [7:0]             r_good_cnt;
  state_e                 r_state;
  logic                   r_pix_rise;
  logic                   r_pix_fall;
  logic                   r_clk_ok;
  logic                   r_clk_fault;
  logic [7:0]             r_fault_count;
  logic [CNT_W-1:0]       r_period_meas;

  logic   w_sync_q;
  logic   w_rise;
  logic   w_fall;
  logic   w_active;
  logic   w_meas_per;
  logic   w_meas_hi;
  logic   w_per_good;
  logic   w_hi_good;
  logic   w_timeout;
  logic   w_bad;
  state_e w_next_state;
  logic   [7:0] w_good_cnt_nxt;
  logic   w_have_ref_nxt;
  logic   w_fault_event;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync_q & ~r_hist;
  assign w_fall   = ~w_sync_q & r_hist;

  // Measurements only count while acquiring or locked, and only once a
  // reference rise has been seen.
  assign w_active   = (r_state == ST_ACQUIRE) || (r_state == ST_LOCKED);
  assign w_meas_per = w_rise & r_have_ref & w_active;
  assign w_meas_hi  = w_fall & r_have_ref & w_active;
  assign w_per_good = abs_diff(r_per_cnt, PER_EXP) <= TOL_W;
  assign w_hi_good  = abs_diff(r_hi_cnt, HI_EXP) <= TOL_W;
  // per_cnt passes TIMEOUT_CNT exactly once per missing edge, and the
  // timeout also drops have_ref, so this fires a single time.
  assign w_timeout  = r_have_ref & w_active & ~w_rise & (r_per_cnt == TIMEOUT_CNT);
  assign w_bad      = (w_meas_per & ~w_per_good) | (w_meas_hi & ~w_hi_good) | w_timeout;

  // Synchronizer, edge detection and measurement counters.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the chain shift.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      // NOTE: the synchronizer is reset too, so no stale level can fake an
      // edge right after reset release.
      r_sync        <= '0;
      r_hist        <= 1'b0;
      r_pix_rise    <= 1'b0;
      r_pix_fall    <= 1'b0;
      r_per_cnt     <= '0;
      r_hi_cnt      <= '0;
      r_period_meas <= '0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], pix_clk};
      r_hist     <= w_sync_q;
      r_pix_rise <= w_rise;
      r_pix_fall <= w_fall;

      if (w_rise)                     r_per_cnt <= CNT_ONE;
      else if (r_per_cnt != CNT_MAX)  r_per_cnt <= r_per_cnt + CNT_ONE;

      if (w_rise)                                  r_hi_cnt <= CNT_ONE;
      else if (w_sync_q && (r_hi_cnt != CNT_MAX))  r_hi_cnt <= r_hi_cnt + CNT_ONE;

      if (w_rise && r_have_ref) r_period_meas <= r_per_cnt;
    end
  end

  // FSM next-state and bookkeeping.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    w_next_state   = r_state;
    w_good_cnt_nxt = r_good_cnt;
    w_have_ref_nxt = r_have_ref;
    w_fault_event  = 1'b0;

    if (w_active && w_rise) w_have_ref_nxt = 1'b1;
    if (w_timeout)          w_have_ref_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (pll_locked) w_next_state = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (w_bad) begin
          w_good_cnt_nxt = 8'd0;
        end else if (w_meas_per && w_per_good) begin
          w_good_cnt_nxt = r_good_cnt + 8'd1;
          if ((r_good_cnt + 8'd1) >= LOCK_N) w_next_state = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_bad) begin
          w_next_state  = ST_FAULT;
          w_fault_event = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_next_state   = ST_ACQUIRE;
          w_good_cnt_nxt = 8'd0;
          w_have_ref_nxt = 1'b0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    // Losing the PLL is not a clock fault: restart quietly from IDLE.
    if (!pll_locked) begin
      w_next_state   = ST_IDLE;
      w_good_cnt_nxt = 8'd0;
      w_have_ref_nxt = 1'b0;
      w_fault_event  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_good_cnt <= 8'd0;
      r_have_ref <= 1'b0;
      r_clk_ok   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_good_cnt <= w_good_cnt_nxt;
      r_have_ref <= w_have_ref_nxt;
      // Registered from next state so clk_ok tracks state==LOCKED exactly.
      r_clk_ok   <= (w_next_state == ST_LOCKED);
    end
  end

  // Sticky fault flag and counter; a fresh fault wins over a same-cycle clear.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_clk_fault   <= 1'b0;
      r_fault_count <= 8'd0;
    end else if (w_fault_event) begin
      r_clk_fault <= 1'b1;
      if (fault_clr)                   r_fault_count <= 8'd1;
      else if (r_fault_count != 8'hFF) r_fault_count <= r_fault_count + 8'd1;
    end else if (fault_clr) begin
      r_clk_fault   <= 1'b0;
      r_fault_count <= 8'd0;
    end
  end

  assign pix_rise    = r_pix_rise;
  assign pix_fall    = r_pix_fall;
  assign clk_ok      = r_clk_ok;
  assign clk_fault   = r_clk_fault;
  assign fault_count = r_fault_count;
  assign period_meas = r_period_meas;

endmodule

// File: tb/tb_pix_clk_monitor.sv
// tb_pix_clk_monitor
//   Directed bench for pix_clk_monitor at default parameters. pix_clk is
//   driven as clk_in/4 (two cycles high, two low) except where a step
//   stretches or stops it. Outputs are sampled 1 time unit after each rising
//   edge of clk_in; inputs change at the same point.
module tb_pix_clk_monitor;
  localparam int CNT_W = 16;

  logic             clk_in;
  logic             rst;
  logic             pix_clk;
  logic             pll_locked;
  logic             fault_clr;
  logic             pix_rise;
  logic             pix_fall;
  logic             clk_ok;
  logic             clk_fault;
  logic [7:0]       fault_count;
  logic [CNT_W-1:0] period_meas;

  int   n_assert  = 0;
  int   n_fail    = 0;
  int   cycle     = 0;
  int   rise_n    = 0;
  int   last_rise = 0;
  int   rise_gap  = 0;
  int   fall_gap  = 0;
  logic prev_ok   = 1'b0;
  logic ok_at     [0:31];
  logic ok_before [0:31];

  pix_clk_monitor #(
    .DIV_PIX(4), .LOCK_PERIODS(8), .TOL(0), .SYNC_STAGES(2), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .rst(rst), .pix_clk(pix_clk), .pll_locked(pll_locked),
    .fault_clr(fault_clr), .pix_rise(pix_rise), .pix_fall(pix_fall),
    .clk_ok(clk_ok), .clk_fault(clk_fault), .fault_count(fault_count),
    .period_meas(period_meas)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clk_in cycle and log edge pulses with the clk_ok around them.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cycle++;
    if (pix_rise === 1'b1) begin
      if (rise_n < 32) begin
        ok_at[rise_n]     = clk_ok;
        ok_before[rise_n] = prev_ok;
      end
      rise_gap  = cycle - last_rise;
      last_rise = cycle;
      rise_n++;
    end
    if (pix_fall === 1'b1) fall_gap = cycle - last_rise;
    prev_ok = clk_ok;
  endtask

  // n periods of 2 high / 2 low; period index 'stretch' gets 4 low (length 6).
  task automatic run_periods(input int n, input int stretch);
    for (int p = 0; p < n; p++) begin
      pix_clk = 1'b1; tick(); tick();
      pix_clk = 1'b0; tick(); tick();
      if (p == stretch) begin tick(); tick(); end
    end
  endtask

  // Run from ACQUIRE and require clk_ok to rise together with pulse lock_idx.
  task automatic run_lock(input string tag, input int n, input int stretch, input int lock_idx);
    rise_n = 0;
    for (int i = 0; i < 32; i++) begin ok_at[i] = 1'b0; ok_before[i] = 1'b0; end
    run_periods(n, stretch);
    chk({tag, "_rises"},     rise_n, n);
    chk({tag, "_ok_before"}, ok_before[lock_idx], 0);
    chk({tag, "_ok_at"},     ok_at[lock_idx], 1);
    chk({tag, "_ok_end"},    clk_ok, 1);
  endtask

  // Hold pix_clk low from LOCKED: per_cnt hits 8 seven cycles after the last
  // pix_rise pulse, and the fault is visible on the following cycle.
  task automatic timeout_fault(input string tag, input int exp_cnt);
    pix_clk = 1'b0;
    while (cycle < last_rise + 7) tick();
    chk({tag, "_ok_pre"}, clk_ok, 1);
    tick();
    chk({tag, "_ok"},    clk_ok, 0);
    chk({tag, "_fault"}, clk_fault, 1);
    chk({tag, "_count"}, fault_count, exp_cnt);
  endtask

  task automatic pll_blip(input string tag, input int exp_fault, input int exp_cnt);
    pll_locked = 1'b0;
    tick();
    chk({tag, "_ok"},    clk_ok, 0);
    chk({tag, "_fault"}, clk_fault, exp_fault);
    chk({tag, "_count"}, fault_count, exp_cnt);
    pll_locked = 1'b1;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    pix_clk    = 1'b0;
    pll_locked = 1'b1;
    fault_clr  = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_rise",   pix_rise, 0);
    chk("rst_ok",     clk_ok, 0);
    chk("rst_fault",  clk_fault, 0);
    chk("rst_count",  fault_count, 0);
    chk("rst_period", period_meas, 0);
    tick(); tick();
    #3 rst = 1'b1;

    // Initial acquisition: reference rise plus 8 good periods.
    run_lock("lock1", 12, -1, 8);
    chk("period_meas", period_meas, 4);
    chk("rise_gap",    rise_gap, 4);
    chk("fall_gap",    fall_gap, 2);
    chk("lock1_fault", clk_fault, 0);

    // Stopped clock while locked.
    timeout_fault("to1", 1);

    // Clear the fault and reacquire.
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    chk("clr_fault", clk_fault, 0);
    chk("clr_count", fault_count, 0);
    chk("clr_ok",    clk_ok, 0);
    run_lock("lock2", 12, -1, 8);

    // PLL drop while locked is not a fault.
    pll_blip("blip1", 0, 0);
    run_lock("lock3", 12, -1, 8);

    // One 6-cycle period after 5 good ones restarts the good-period run.
    pll_blip("blip2", 0, 0);
    run_lock("stretch", 18, 5, 14);
    chk("stretch_no9",    ok_at[8], 0);
    chk("stretch_nofault", clk_fault, 0);

    // Fault survives a PLL drop; a second fault counts to 2.
    timeout_fault("to2", 1);
    pll_blip("blip3", 1, 1);
    run_lock("lock4", 12, -1, 8);
    chk("lock4_fault", clk_fault, 1);
    timeout_fault("to3", 2);
    pll_blip("blip4", 1, 2);
    run_lock("lock5", 12, -1, 8);

    // Asynchronous reset between edges while locked, with a rise pulse live.
    pix_clk = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_rise",  pix_rise, 1);
    chk("pre_rst_ok",    clk_ok, 1);
    chk("pre_rst_count", fault_count, 2);
    #3 rst = 1'b0;
    #1;
    chk("arst_rise",   pix_rise, 0);
    chk("arst_fall",   pix_fall, 0);
    chk("arst_ok",     clk_ok, 0);
    chk("arst_fault",  clk_fault, 0);
    chk("arst_count",  fault_count, 0);
    chk("arst_period", period_meas, 0);
    tick(); tick();
    #4 rst = 1'b1;
    tick();
    chk("rel_rise1", pix_rise, 0);
    tick();
    chk("rel_rise2", pix_rise, 0);
    tick();
    chk("rel_rise3", pix_rise, 1);
    chk("rel_ok",    clk_ok, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
